// File: rtl/result_uart_tx.sv
// result_uart_tx: sends the classifier's class index as one ASCII digit over
// a UART TX line (8N1, LSB first), optionally followed by CR LF. It pulses
// tx_done once after the last stop bit and then waits for rd to drop before
// it will accept another result.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   rd       classifier result-ready level, held high until tx_done
//   din      classifier result {4'h0, class_index[3:0]}
//   tx       UART serial line, idle high
//   tx_done  one-cycle pulse once the whole message has been sent
//   busy     high from capture through the tx_done cycle
module result_uart_tx #(
   parameter int unsigned CLK_DIV      = 434,  // clocks per UART bit, 2..65535
   parameter int unsigned SEND_NEWLINE = 1     // 1: digit, CR, LF; 0: digit only
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd,
   input  logic [7:0] din,
   output logic       tx,
   output logic       tx_done,
   output logic       busy
);

   localparam int unsigned      CNT_W     = 16;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [1:0]       LAST_BYTE = (SEND_NEWLINE != 0) ? 2'd2 : 2'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE,
      S_REARM
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             tx_done_q, tx_done_d;
   logic             busy_q, busy_d;

   logic [7:0]       ascii_c;
   logic             bit_end_c;
   logic             din_unused_c;

   // Class index to ASCII digit; anything above 9 becomes '?'.
   assign ascii_c      = (din[3:0] <= 4'd9) ? (8'h30 + 8'(din[3:0])) : 8'h3F;
   assign din_unused_c = ^din[7:4];
   assign bit_end_c    = (cnt_q == '0);

   // Next-state logic. tx and tx_done are decoded from the current state and
   // registered, so the line lags the state by one cycle; this gives the
   // one-cycle gap between capture and the start bit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      tx_d       = 1'b1;
      tx_done_d  = 1'b0;
      busy_d     = busy_q;

      // busy covers the tx_done cycle and drops right after it.
      if (tx_done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (rd) begin
               shift_d    = ascii_c;
               byte_idx_d = 2'd0;
               bit_idx_d  = 3'd0;
               cnt_d      = BIT_LAST;
               busy_d     = 1'b1;
               state_d    = S_START;
            end
         end

         S_START: begin
            tx_d = 1'b0;
            if (bit_end_c) begin
               cnt_d     = BIT_LAST;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_DATA: begin
            tx_d = shift_q[0];
            if (bit_end_c) begin
               cnt_d   = BIT_LAST;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_STOP: begin
            tx_d = 1'b1;
            if (bit_end_c) begin
               cnt_d = BIT_LAST;
               // Chain the next byte straight into its start bit.
               if (byte_idx_q != LAST_BYTE) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  shift_d    = (byte_idx_q == 2'd0) ? 8'h0D : 8'h0A;
                  state_d    = S_START;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_DONE: begin
            tx_done_d = 1'b1;
            state_d   = S_REARM;
         end

         S_REARM: begin
            // A level that stays high must not start a second message.
            if (!rd) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
         busy_q     <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = tx_done_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed bench for result_uart_tx. dut0 sends the digit
// only, dut1 sends digit + CR LF; both use a 4-clock bit period. Every cycle
// of each message is compared against a frame built from hand-computed bytes.
module tb_result_uart_tx;

   localparam int unsigned CDIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd0, rd1;
   logic [7:0] din0, din1;
   logic       tx0, tx1, done0, done1, busy0, busy1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   result_uart_tx #(.CLK_DIV(CDIV), .SEND_NEWLINE(0)) dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd      (rd0),
      .din     (din0),
      .tx      (tx0),
      .tx_done (done0),
      .busy    (busy0)
   );

   result_uart_tx #(.CLK_DIV(CDIV), .SEND_NEWLINE(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd      (rd1),
      .din     (din1),
      .tx      (tx1),
      .tx_done (done1),
      .busy    (busy1)
   );

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic sample(input bit sel, output logic t, output logic d, output logic b);
      t = sel ? tx1   : tx0;
      d = sel ? done1 : done0;
      b = sel ? busy1 : busy0;
   endtask

   // Raise rd with din=d and check every cycle until busy has dropped.
   // k counts rising edges after the one that samples rd high.
   task automatic run_msg(input string tag, input bit sel, input logic [7:0] d,
                          input logic [7:0] b0, input bit keep_rd,
                          input logic [7:0] din_mid, input bit drop_mid);
      int         nbytes;
      int         total;
      int         bi;
      int         pos;
      logic [7:0] bytes [3];
      logic [7:0] cur;
      logic       t, dn, b, exp_tx;
      nbytes   = sel ? 3 : 1;
      total    = 10 * CDIV * nbytes;
      bytes[0] = b0;
      bytes[1] = 8'h0D;
      bytes[2] = 8'h0A;
      @(negedge clk);
      if (sel) begin rd1 = 1'b1; din1 = d; end
      else     begin rd0 = 1'b1; din0 = d; end
      @(posedge clk);
      for (int k = 0; k <= total + 2; k++) begin
         @(negedge clk);
         sample(sel, t, dn, b);
         if (k == 0 || k > total) begin
            exp_tx = 1'b1;
         end else begin
            bi  = (k - 1) / CDIV;
            pos = bi % 10;
            cur = bytes[bi / 10];
            if (pos == 0)      exp_tx = 1'b0;
            else if (pos == 9) exp_tx = 1'b1;
            else               exp_tx = cur[pos - 1];
         end
         check($sformatf("%s tx k=%0d", tag, k), t, exp_tx);
         check($sformatf("%s tx_done k=%0d", tag, k), dn, (k == total + 1));
         check($sformatf("%s busy k=%0d", tag, k), b, (k <= total + 1));
         if (k == 10) begin
            if (sel) din1 = din_mid; else din0 = din_mid;
         end
         if (k == 5 && drop_mid) begin
            if (sel) rd1 = 1'b0; else rd0 = 1'b0;
         end
      end
      if (!keep_rd) begin
         if (sel) rd1 = 1'b0; else rd0 = 1'b0;
      end
   endtask

   initial begin
      int viol;
      rst_n = 1'b0;
      rd0   = 1'b0;
      rd1   = 1'b0;
      din0  = 8'h00;
      din1  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset tx0", tx0, 1'b1);
      check("reset done0", done0, 1'b0);
      check("reset busy0", busy0, 1'b0);
      check("reset tx1", tx1, 1'b1);
      check("reset done1", done1, 1'b0);
      check("reset busy1", busy1, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic digit, digit + CR LF, invalid indices, upper nibble ignored.
      run_msg("t1_d7",   1'b0, 8'h07, 8'h37, 1'b0, 8'h07, 1'b0);
      run_msg("t2_nl3",  1'b1, 8'h03, 8'h33, 1'b0, 8'h03, 1'b0);
      run_msg("t3_invC", 1'b0, 8'h0C, 8'h3F, 1'b0, 8'h0C, 1'b0);
      run_msg("t3_invA", 1'b0, 8'h0A, 8'h3F, 1'b0, 8'h0A, 1'b0);
      run_msg("t3_hi9",  1'b1, 8'hF9, 8'h39, 1'b0, 8'hF9, 1'b0);

      // din change and rd drop mid-message.
      run_msg("t6_dinchg", 1'b0, 8'h02, 8'h32, 1'b0, 8'h05, 1'b0);
      run_msg("t6_rddrop", 1'b1, 8'h08, 8'h38, 1'b0, 8'h08, 1'b1);

      // rd held high after tx_done: no restart until it drops.
      run_msg("t4_hold", 1'b0, 8'h05, 8'h35, 1'b1, 8'h05, 1'b0);
      viol = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) viol++;
      end
      check("t4 held rd idle violations", viol, 0);
      rd0 = 1'b0;
      run_msg("t4_rearm", 1'b0, 8'h05, 8'h35, 1'b0, 8'h05, 1'b0);

      // Reset during the third data bit, then a clean frame.
      @(negedge clk);
      rd0  = 1'b1;
      din0 = 8'h07;
      @(posedge clk);
      repeat (15) @(negedge clk);
      check("t5 tx in data bit 2", tx0, 1'b1);
      check("t5 busy in data bit 2", busy0, 1'b1);
      rst_n = 1'b0;
      rd0   = 1'b0;
      @(negedge clk);
      check("t5 rst tx", tx0, 1'b1);
      check("t5 rst busy", busy0, 1'b0);
      check("t5 rst tx_done", done0, 1'b0);
      rst_n = 1'b1;
      viol  = 0;
      repeat (3) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) viol++;
      end
      check("t5 idle after reset violations", viol, 0);
      run_msg("t5_after_rst", 1'b0, 8'h07, 8'h37, 1'b0, 8'h07, 1'b0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
